mbist_addr_scan_ctrl: RTL and testbench

Scan-chain host for the MBIST address generator's serial start/end address chain. It takes a parallel start/end address request and drives the generator's bist_shift/sdi for 2*BIST_ADDR_WD cycles. During the same cycles it captures the chain's previous contents from sdo, then optionally pulses bist_load so the generator restarts at the new start address. It sits in the MBIST controller between the register/config interface and each address generator instance.

---
 rtl/mbist_pkg.sv | 11 +
 rtl/mbist_addr_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_mbist_addr_scan_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mbist_pkg.sv
// Shared MBIST definitions: scan-host FSM state encoding.
package mbist_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StLoad  = 2'd2,
    StDone  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/mbist_addr_scan_ctrl.sv
// Scan-chain host for the MBIST address generator start/end chain. Shifts a new
// {start,end} pair in LSB-of-end first while capturing the old chain contents from
// sdo, then optionally pulses bist_load and reports read-back data with cfg_done.
module mbist_addr_scan_ctrl
  import mbist_pkg::*;
#(
  parameter int unsigned BIST_ADDR_WD = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_req,
  input  logic [BIST_ADDR_WD-1:0] cfg_start_addr,
  input  logic [BIST_ADDR_WD-1:0] cfg_end_addr,
  input  logic                    cfg_load_en,
  output logic                    cfg_busy,
  output logic                    cfg_done,
  output logic [BIST_ADDR_WD-1:0] rd_start_addr,
  output logic [BIST_ADDR_WD-1:0] rd_end_addr,
  output logic                    bist_shift,
  output logic                    bist_load,
  output logic                    sdi,
  input  logic                    sdo
);

  localparam int unsigned CHAIN_LEN = 2 * BIST_ADDR_WD;
  localparam int unsigned CntW      = $clog2(CHAIN_LEN + 1);
  localparam int unsigned W         = BIST_ADDR_WD;

  scan_state_e           state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0]  tx_sr_q, tx_sr_d;
  logic [CHAIN_LEN-1:0]  cap_sr_q, cap_sr_d;
  logic                  load_en_q, load_en_d;
  logic [W-1:0]          rd_start_q, rd_start_d;
  logic [W-1:0]          rd_end_q, rd_end_d;
  logic                  shift_q, shift_d;
  logic                  load_q, load_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  // Next-state logic: FSM, shift registers, counter and registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_sr_d    = tx_sr_q;
    cap_sr_d   = cap_sr_q;
    load_en_d  = load_en_q;
    rd_start_d = rd_start_q;
    rd_end_d   = rd_end_q;

    unique case (state_q)
      StIdle: begin
        if (cfg_req) begin
          tx_sr_d   = {cfg_start_addr, cfg_end_addr};
          load_en_d = cfg_load_en;
          cnt_d     = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        tx_sr_d  = {1'b0, tx_sr_q[CHAIN_LEN-1:1]};
        // sdo is the old chain bit presented this cycle, before the generator shifts.
        cap_sr_d = {sdo, cap_sr_q[CHAIN_LEN-1:1]};
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(CHAIN_LEN - 1)) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        rd_start_d = cap_sr_q[CHAIN_LEN-1:W];
        rd_end_d   = cap_sr_q[W-1:0];
        state_d    = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are decoded from the next state so they come straight from flops.
    shift_d = (state_d == StShift);
    load_d  = (state_d == StLoad) && load_en_d;
    done_d  = (state_d == StDone);
    busy_d  = (state_d != StIdle);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tx_sr_q    <= '0;
      cap_sr_q   <= '0;
      load_en_q  <= 1'b0;
      rd_start_q <= '0;
      rd_end_q   <= '0;
      shift_q    <= 1'b0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_sr_q    <= tx_sr_d;
      cap_sr_q   <= cap_sr_d;
      load_en_q  <= load_en_d;
      rd_start_q <= rd_start_d;
      rd_end_q   <= rd_end_d;
      shift_q    <= shift_d;
      load_q     <= load_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  // Output mapping; sdi is forced low outside shifting.
  always_comb begin
    cfg_busy      = busy_q;
    cfg_done      = done_q;
    rd_start_addr = rd_start_q;
    rd_end_addr   = rd_end_q;
    bist_shift    = shift_q;
    bist_load     = load_q;
    sdi           = shift_q & tx_sr_q[0];
  end

endmodule

// File: tb/tb_mbist_addr_scan_ctrl.sv
// Bench for mbist_addr_scan_ctrl paired with a behavioural address-generator chain.
module tb_mbist_addr_scan_ctrl;

  localparam int unsigned W = 9;

  logic         clk;
  logic         rst_n;
  logic         cfg_req;
  logic [W-1:0] cfg_start_addr;
  logic [W-1:0] cfg_end_addr;
  logic         cfg_load_en;
  logic         cfg_busy;
  logic         cfg_done;
  logic [W-1:0] rd_start_addr;
  logic [W-1:0] rd_end_addr;
  logic         bist_shift;
  logic         bist_load;
  logic         sdi;
  logic         sdo;

  int checks;
  int errors;

  mbist_addr_scan_ctrl #(.BIST_ADDR_WD(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_req        (cfg_req),
    .cfg_start_addr (cfg_start_addr),
    .cfg_end_addr   (cfg_end_addr),
    .cfg_load_en    (cfg_load_en),
    .cfg_busy       (cfg_busy),
    .cfg_done       (cfg_done),
    .rd_start_addr  (rd_start_addr),
    .rd_end_addr    (rd_end_addr),
    .bist_shift     (bist_shift),
    .bist_load      (bist_load),
    .sdi            (sdi),
    .sdo            (sdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator chain: sdi -> start[8..0] -> end[8..0] -> sdo; reset start=0x000 end=0x1F8.
  logic [2*W-1:0] gen_chain;
  logic [W-1:0]   gen_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_chain <= {9'h000, 9'h1F8};
      gen_addr  <= '0;
    end else begin
      if (bist_shift) gen_chain <= {sdi, gen_chain[2*W-1:1]};
      if (bist_load)  gen_addr  <= gen_chain[2*W-1:W];
    end
  end
  assign sdo = gen_chain[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transfer; samples each cycle at the negedge, k = cycles after the accept edge.
  task automatic run_xfer(input logic [W-1:0] s, input logic [W-1:0] e, input logic ld,
                          input bit disturb, input int rst_at,
                          input logic [W-1:0] exp_rs, input logic [W-1:0] exp_re);
    int n_shift = 0, n_load = 0, n_done = 0, overlap = 0, busy_err = 0;
    int first_sh = 0, last_sh = 0, load_cyc = 0, done_cyc = 0;
    logic [W-1:0] rs = '0, re = '0;
    @(negedge clk);
    cfg_start_addr = s;
    cfg_end_addr   = e;
    cfg_load_en    = ld;
    cfg_req        = 1'b1;
    @(posedge clk);
    #1 cfg_req = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bist_shift) begin
        n_shift++;
        if (first_sh == 0) first_sh = k;
        last_sh = k;
      end
      if (bist_load) begin
        n_load++;
        load_cyc = k;
      end
      if (bist_shift && bist_load) overlap++;
      if (cfg_done) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc = k;
          rs = rd_start_addr;
          re = rd_end_addr;
        end
      end
      if (k <= 20 && !cfg_busy) busy_err++;
      if (k == 21) check("busy_low_after_done", {31'd0, cfg_busy}, 32'd0);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_outs_zero",
              {18'd0, cfg_busy, cfg_done, bist_shift, bist_load, sdi, 9'd0}, 32'd0);
        check("rst_rd_zero", {14'd0, rd_start_addr, rd_end_addr}, 32'd0);
        @(negedge clk);
        check("rst_hold_shift", {31'd0, bist_shift}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_idle_busy", {31'd0, cfg_busy}, 32'd0);
        return;
      end
      if (disturb && k >= 2 && k <= 17) begin
        cfg_req        = k[0];
        cfg_start_addr = s ^ W'(k);
        cfg_end_addr   = e ^ W'(k * 3);
        cfg_load_en    = ~ld;
      end
      if (disturb && k == 18) cfg_req = 1'b0;
    end
    check("shift_count", n_shift, 18);
    check("shift_first", first_sh, 1);
    check("shift_last", last_sh, 18);
    check("load_count", n_load, ld ? 1 : 0);
    if (ld) check("load_cycle", load_cyc, 19);
    check("done_count", n_done, 1);
    check("done_cycle", done_cyc, 20);
    check("shift_load_overlap", overlap, 0);
    check("busy_window", busy_err, 0);
    check("rd_start", {23'd0, rs}, {23'd0, exp_rs});
    check("rd_end", {23'd0, re}, {23'd0, exp_re});
    check("rd_held", {14'd0, rd_start_addr, rd_end_addr}, {14'd0, exp_rs, exp_re});
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    cfg_req        = 1'b0;
    cfg_start_addr = '0;
    cfg_end_addr   = '0;
    cfg_load_en    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {27'd0, cfg_busy, cfg_done, bist_shift, bist_load, sdi}, 32'd0);
    check("reset_rd", {14'd0, rd_start_addr, rd_end_addr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", {27'd0, cfg_busy, cfg_done, bist_shift, bist_load, sdi}, 32'd0);

    // First transfer reads the generator's reset contents.
    run_xfer(9'h010, 9'h0F0, 1'b1, 1'b0, 0, 9'h000, 9'h1F8);
    check("gen_chain_1", {14'd0, gen_chain}, {14'd0, 9'h010, 9'h0F0});
    check("gen_addr_1", {23'd0, gen_addr}, 32'h010);

    run_xfer(9'h155, 9'h0AA, 1'b1, 1'b0, 0, 9'h010, 9'h0F0);
    check("gen_chain_2", {14'd0, gen_chain}, {14'd0, 9'h155, 9'h0AA});
    check("gen_addr_2", {23'd0, gen_addr}, 32'h155);

    // No load: generator address must stay at the previous start.
    run_xfer(9'h020, 9'h030, 1'b0, 1'b0, 0, 9'h155, 9'h0AA);
    check("gen_chain_3", {14'd0, gen_chain}, {14'd0, 9'h020, 9'h030});
    check("gen_addr_3", {23'd0, gen_addr}, 32'h155);

    // Request and data wiggled while busy; first request's values must win.
    run_xfer(9'h1AB, 9'h044, 1'b1, 1'b1, 0, 9'h020, 9'h030);
    check("gen_chain_4", {14'd0, gen_chain}, {14'd0, 9'h1AB, 9'h044});
    check("gen_addr_4", {23'd0, gen_addr}, 32'h1AB);

    run_xfer(9'h0C3, 9'h111, 1'b1, 1'b0, 0, 9'h1AB, 9'h044);
    check("gen_chain_5", {14'd0, gen_chain}, {14'd0, 9'h0C3, 9'h111});

    // Reset in shift cycle 7, then a fresh transfer sees reset chain contents.
    run_xfer(9'h07F, 9'h100, 1'b1, 1'b0, 7, 9'h000, 9'h000);
    run_xfer(9'h0AB, 9'h0CD, 1'b1, 1'b0, 0, 9'h000, 9'h1F8);
    check("gen_chain_6", {14'd0, gen_chain}, {14'd0, 9'h0AB, 9'h0CD});
    check("gen_addr_6", {23'd0, gen_addr}, 32'h0AB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
